pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with optional two-entry skid buffer.
// Handshake: a beat moves across an interface on a rising edge where its
// valid and ready are both 1; valid never waits on ready, and a producer
// holding valid keeps ctrl/data stable until the transfer happens.
// Skid=1 registers in_ready_o, which breaks the ready path from
// downstream. Skid=0 is a single register with combinational ready.
// The ctrl bundle is forced to zero whenever no beat is held, so a bubble
// never carries a write or store enable. Data is left as it was.
module pipe_stage_skid #(
    parameter int Width     = 32,
    parameter int CtrlWidth = 8,
    parameter int Skid      = 1,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CtrlWidth-1:0] in_ctrl_i,
    input  logic [Width-1:0]     in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CtrlWidth-1:0] out_ctrl_o,
    output logic [Width-1:0]     out_data_o,
    input  logic                 stall_cnt_clr_i,
    output logic [CntWidth-1:0]  stall_cnt_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;
    logic                 stall;
    logic [CtrlWidth-1:0] main_ctrl_q;
    logic [Width-1:0]     main_data_q;
    logic [CtrlWidth-1:0] skid_ctrl_q;
    logic [Width-1:0]     skid_data_q;
    logic [CntWidth-1:0]  stall_cnt_q;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;
    assign stall_cnt_o = stall_cnt_q;
    assign dbg_state_o = state_q;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;
    assign stall    = out_valid_o & ~out_ready_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and entry-load selects; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d      = ST_FULL;
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    // Only reachable with a skid entry: single-entry ready
                    // already requires out_ready_i when full.
                    if (Skid != 0) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else begin
                        load_main_in = 1'b1;
                    end
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_d        = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush_i) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Main entry: ctrl cleared whenever the stage goes empty, data retained.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            if (state_d == ST_EMPTY) begin
                main_ctrl_q <= '0;
            end else if (load_main_in) begin
                main_ctrl_q <= in_ctrl_i;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_main_in) begin
                main_data_q <= in_data_i;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
            end
        end
    end

    // Skid entry: ctrl cleared whenever the skid slot is not occupied.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (state_d != ST_SKID) begin
                skid_ctrl_q <= '0;
            end else if (load_skid) begin
                skid_ctrl_q <= in_ctrl_i;
            end
            if (load_skid) begin
                skid_data_q <= in_data_i;
            end
        end
    end

    // Saturating back-pressure counter; clear wins, flush leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CntWidth{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CntWidth'(1);
        end
    end

    generate
        if (Skid != 0) begin : g_skid_ready
            logic in_ready_q;
            // Registered ready: open whenever the next state leaves room.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_d != ST_SKID);
                end
            end
            assign in_ready_o = in_ready_q;
        end else begin : g_single_ready
            assign in_ready_o = ~rst_i & (~out_valid_o | out_ready_i);
        end
    endgenerate

endmodule
